// File: rtl/alu_issue_ctrl_if.sv
// Request/response channel bundle between a requester and alu_issue_ctrl.
// The master modport is the requester side; the slave modport is the controller.
interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_error;

  modport master (
    output req_valid, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_error
  );

  modport slave (
    input  req_valid, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_error
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: request-side controller for the 32-bit ALU.
// Accepts one MIPS R-type request at a time, decodes funct into the ALU
// opcode, drives registered operands/opcode, sequences the multi-cycle MOD
// path (reset pulse followed by MOD_CYCLES wait cycles) and returns the
// captured ALU result on a valid/ready response channel.
// Optional feature: define ALU_DIV0_CHECK_EN to reject MOD by zero with an
// error response instead of issuing it to the ALU.
module alu_issue_ctrl #(
  parameter int unsigned MOD_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             CLK,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_reset,
  input  logic [31:0]      alu_result
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
    MOD_RST  = 3'd2,
    MOD_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam logic [2:0]       OP_MOD   = 3'b111;
  localparam logic [CNT_W-1:0] MOD_LOAD = CNT_W'(MOD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Returns {supported, alu_op} for a MIPS funct field.
  function automatic logic [3:0] decode_funct(input logic [5:0] funct);
    logic [3:0] dec;
    case (funct)
      6'h24:   dec = {1'b1, 3'b000}; // AND
      6'h25:   dec = {1'b1, 3'b001}; // OR
      6'h26:   dec = {1'b1, 3'b010}; // XOR
      6'h27:   dec = {1'b1, 3'b011}; // NOR
      6'h2A:   dec = {1'b1, 3'b100}; // SLT
      6'h20:   dec = {1'b1, 3'b101}; // ADD
      6'h22:   dec = {1'b1, 3'b110}; // SUB
      6'h1A:   dec = {1'b1, 3'b111}; // remainder (MOD)
      default: dec = {1'b0, 3'b000};
    endcase
    return dec;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       alu_a_q, alu_a_d;
  logic [31:0]       alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [31:0]       result_q, result_d;
  logic              error_q, error_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              mod_pulse_q, mod_pulse_d;

  logic [3:0]        dec_s;
  logic              accept_s;
  logic              div0_s;

  assign dec_s    = decode_funct(bus.req_funct);
  assign accept_s = ready_q & bus.req_valid;

`ifdef ALU_DIV0_CHECK_EN
  assign div0_s = (bus.req_b == 32'd0);
`else
  assign div0_s = 1'b0;
`endif

  // Next-state, datapath and output-register next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          alu_a_d = bus.req_a;
          alu_b_d = bus.req_b;
          if (!dec_s[3]) begin
            // Unsupported funct: answer immediately, ALU opcode untouched.
            result_d = 32'd0;
            error_d  = 1'b1;
            state_d  = RESP;
          end else if ((dec_s[2:0] == OP_MOD) && div0_s) begin
            // Rejected MOD by zero: no ALU reset pulse is issued.
            result_d = 32'd0;
            error_d  = 1'b1;
            state_d  = RESP;
          end else if (dec_s[2:0] == OP_MOD) begin
            alu_op_d = dec_s[2:0];
            state_d  = MOD_RST;
          end else begin
            alu_op_d = dec_s[2:0];
            state_d  = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = alu_result;
        error_d  = 1'b0;
        state_d  = RESP;
      end
      MOD_RST: begin
        cnt_d   = MOD_LOAD;
        state_d = MOD_WAIT;
      end
      MOD_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        // The <= guards against a zero count ever wrapping the wait.
        if (cnt_q <= CNT_ONE) begin
          result_d = alu_result;
          error_d  = 1'b0;
          state_d  = RESP;
        end else begin
          state_d = MOD_WAIT;
        end
      end
      RESP: begin
        if (valid_q && bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d     = (state_d == IDLE);
    valid_d     = (state_d == RESP);
    mod_pulse_d = (state_d == MOD_RST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_op_q    <= 3'd0;
      result_q    <= 32'd0;
      error_q     <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      mod_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      result_q    <= result_d;
      error_q     <= error_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      mod_pulse_q <= mod_pulse_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_error  = error_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_op         = alu_op_q;
  // The ALU must see reset as soon as the system reset is asserted.
  assign alu_reset      = reset | mod_pulse_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a response
// scoreboard. Honours ALU_DIV0_CHECK_EN when it is defined for the build.
module tb_alu_issue_ctrl;

  localparam int MOD_CYCLES = 8;

  typedef struct {
    logic [31:0] result;
    logic        error;
    int          latency;
    int          pulses;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_reset;
  logic [31:0] alu_result;
  int          mod_cnt;

  int checks;
  int fails;
  exp_t exp_q[$];

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.MOD_CYCLES(MOD_CYCLES), .CNT_W(4)) dut (
    .CLK        (clk),
    .reset      (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_reset  (alu_reset),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles elapsed since the ALU last saw its reset input high.
  always @(posedge clk) begin
    if (alu_reset) mod_cnt <= 0;
    else if (mod_cnt < 1000) mod_cnt <= mod_cnt + 1;
  end

  // Behavioural ALU: MOD only yields a real value once MOD_CYCLES have passed.
  always_comb begin
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a ^ alu_b;
      3'b011: alu_result = ~(alu_a | alu_b);
      3'b100: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      3'b101: alu_result = alu_a + alu_b;
      3'b110: alu_result = alu_a - alu_b;
      default: begin
        if (mod_cnt < MOD_CYCLES - 1) alu_result = 32'hDEAD_BEEF;
        else if (alu_b == 32'd0)      alu_result = 32'hFFFF_FFFF;
        else                          alu_result = alu_a % alu_b;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its response and compare against the scoreboard.
  task automatic do_req(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] eop,
                        input logic [31:0] eres, input logic eerr,
                        input int elat, input int epulse, input int hold);
    int   n;
    int   pulses;
    exp_t e;
    exp_q.push_back('{result: eres, error: eerr, latency: elat, pulses: epulse});
    @(negedge clk);
    bus.rsp_ready = (hold > 0) ? 1'b0 : 1'b1;
    bus.req_valid = 1'b1;
    bus.req_funct = f;
    bus.req_a     = a;
    bus.req_b     = b;
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    n = 0;
    pulses = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.req_valid = 1'b0;
        check({tag, "_alu_op"}, {29'd0, alu_op}, {29'd0, eop});
      end
      if (alu_reset) pulses++;
    end while (!bus.rsp_valid && n < 200);
    e = exp_q.pop_front();
    check({tag, "_latency"}, 32'(n), 32'(e.latency));
    check({tag, "_result"}, bus.rsp_result, e.result);
    check({tag, "_error"}, {31'd0, bus.rsp_error}, {31'd0, e.error});
    check({tag, "_pulses"}, 32'(pulses), 32'(e.pulses));
    check({tag, "_busy"}, {31'd0, bus.req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_funct = 6'h22;
      bus.req_a     = ~a;
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      check({tag, "_hold_result"}, bus.rsp_result, e.result);
      check({tag, "_hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      check({tag, "_no_accept"}, alu_a, a);
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_consumed"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_funct = 6'd0;
    bus.req_a = 32'd0;
    bus.req_b = 32'd0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_reset", {31'd0, alu_reset}, 32'd1);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("post_rst_alu_reset", {31'd0, alu_reset}, 32'd0);

    do_req("add",   6'h20, 32'd5, 32'd7, 3'b101, 32'd12, 1'b0, 2, 0, 0);
    do_req("sub",   6'h22, 32'd3, 32'd5, 3'b110, 32'hFFFF_FFFE, 1'b0, 2, 0, 0);
    do_req("slt",   6'h2A, 32'hFFFF_FFFF, 32'd1, 3'b100, 32'd1, 1'b0, 2, 0, 0);
    do_req("nor",   6'h27, 32'd0, 32'd0, 3'b011, 32'hFFFF_FFFF, 1'b0, 2, 0, 0);
    do_req("unsup", 6'h08, 32'd9, 32'd9, 3'b011, 32'd0, 1'b1, 1, 0, 0);
    do_req("mod",   6'h1A, 32'd17, 32'd5, 3'b111, 32'd2, 1'b0, 2 + MOD_CYCLES, 1, 0);
    do_req("and",   6'h24, 32'h0000_F0F0, 32'h0000_FF00, 3'b000, 32'h0000_F000, 1'b0, 2, 0, 0);
    do_req("or",    6'h25, 32'h0000_F0F0, 32'h0000_FF00, 3'b001, 32'h0000_FFF0, 1'b0, 2, 0, 0);
    do_req("xor",   6'h26, 32'h0000_F0F0, 32'h0000_FF00, 3'b010, 32'h0000_0FF0, 1'b0, 2, 0, 0);
    do_req("slt_p", 6'h2A, 32'd1, 32'hFFFF_FFFF, 3'b100, 32'd0, 1'b0, 2, 0, 0);
    do_req("hold",  6'h20, 32'h7FFF_FFFF, 32'd1, 3'b101, 32'h8000_0000, 1'b0, 2, 0, 5);
    do_req("wrap",  6'h20, 32'hFFFF_FFFF, 32'd2, 3'b101, 32'd1, 1'b0, 2, 0, 0);

    // Reset while a MOD is waiting on the ALU.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_funct = 6'h1A;
    bus.req_a = 32'd100;
    bus.req_b = 32'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_alu_reset_hi", {31'd0, alu_reset}, 32'd1);
    @(posedge clk);
    #1;
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("abort_alu_op", {29'd0, alu_op}, 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_rsp_result", bus.rsp_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("abort_alu_reset_lo", {31'd0, alu_reset}, 32'd0);
    repeat (MOD_CYCLES + 4) @(posedge clk);
    #1;
    check("abort_discarded", {31'd0, bus.rsp_valid}, 32'd0);

    do_req("add2", 6'h20, 32'd40, 32'd2, 3'b101, 32'd42, 1'b0, 2, 0, 0);
`ifdef ALU_DIV0_CHECK_EN
    do_req("mod0", 6'h1A, 32'd9, 32'd0, 3'b101, 32'd0, 1'b1, 1, 0, 0);
`else
    do_req("mod0", 6'h1A, 32'd9, 32'd0, 3'b111, 32'hFFFF_FFFF, 1'b0, 2 + MOD_CYCLES, 1, 0);
`endif
    do_req("mod2", 6'h1A, 32'd100, 32'd7, 3'b111, 32'd2, 1'b0, 2 + MOD_CYCLES, 1, 0);

    checks++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
